// File: rtl/sevenseg_mux_if.sv
// Bundle of the display controller's data inputs and scan outputs.
// The master drives the digit data and load strobe; the slave (the mux) drives the display pins.
interface sevenseg_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, load, dp_mask, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, load, dp_mask, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/sevenseg_mux.sv
// Time-multiplexed seven-segment display driver.
// Each digit gets a slot of DIV cycles; the first cycle of every slot is dead time with all
// anodes off so the previous digit's pattern never ghosts onto the next one. Digit data is
// held in shadow registers loaded by a level-sampled load strobe. All outputs are registered.
module sevenseg_mux #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIV            = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input logic             clk,
    input logic             reset_n,
    sevenseg_mux_if.slave   bus
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    // Segment codes are generated active-low (a..g) and flipped at the end if needed.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        unique case (nib)
            4'h0: code = 7'b0000001;
            4'h1: code = 7'b1001111;
            4'h2: code = 7'b0010010;
            4'h3: code = 7'b0000110;
            4'h4: code = 7'b1001100;
            4'h5: code = 7'b0100100;
            4'h6: code = 7'b0100000;
            4'h7: code = 7'b0001111;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0001100;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b1100000;
            4'hC: code = 7'b0110001;
            4'hD: code = 7'b1000010;
            4'hE: code = 7'b0110000;
            4'hF: code = 7'b0111000;
        endcase
        return code;
    endfunction

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
    logic                    blz_q, blz_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic                    cnt_wrap;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    blank_sel;
    logic                    zero_above;
    logic                    active;
    logic [6:0]              seg_al;
    logic                    dp_al;

    // Slot counter and digit index; the index steps only when the slot counter wraps.
    always_comb begin
        cnt_wrap = (cnt_q == CntLast);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
    end

    // Shadow capture; load is sampled every edge, independent of scan position.
    always_comb begin
        val_d = bus.load ? bus.value    : val_q;
        dpm_d = bus.load ? bus.dp_mask  : dpm_q;
        blz_d = bus.load ? bus.blank_lz : blz_q;
    end

    // Select the current digit and decide blanking; scan from the top so zero_above
    // accumulates "this nibble and every one above it is zero".
    always_comb begin
        nib_sel    = 4'h0;
        dp_sel     = 1'b0;
        blank_sel  = 1'b0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (val_q[4*i +: 4] == 4'h0);
            if (idx_q == IdxW'(i)) begin
                nib_sel   = val_q[4*i +: 4];
                dp_sel    = dpm_q[i];
                blank_sel = (i != 0) && blz_q && zero_above;
            end
        end
    end

    // Next output values from the pre-edge scan position and shadow state.
    always_comb begin
        active = (cnt_q != '0) && !blank_sel;
        seg_al = active ? hex_to_seg(nib_sel) : 7'b1111111;
        dp_al  = !(active && dp_sel);
        an_d   = active ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d  = SEG_ACTIVE_LOW ? seg_al : ~seg_al;
        dp_d   = SEG_ACTIVE_LOW ? dp_al  : ~dp_al;
        fd_d   = cnt_wrap && (idx_q == IdxLast);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            val_q <= '0;
            dpm_q <= '0;
            blz_q <= 1'b0;
            seg_q <= SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
            dp_q  <= SEG_ACTIVE_LOW;
            an_q  <= '1;
            fd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            val_q <= val_d;
            dpm_q <= dpm_d;
            blz_q <= blz_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            fd_q  <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Self-checking bench for sevenseg_mux (4 digits, 4 cycles per slot, active-low segments).
// The reference model tracks elapsed cycles since reset release and derives slot position
// with division/modulo, plus shadow copies of the loaded data.
module tb_sevenseg_mux;

    localparam int N = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    sevenseg_mux_if #(.NUM_DIGITS(N)) bus ();

    sevenseg_mux #(
        .NUM_DIGITS     (N),
        .DIV            (D),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [12:0] IDLE_VEC = {7'b1111111, 1'b1, 4'b1111, 1'b0};

    // Model state: cycles since reset release and shadow data.
    int          m_t = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dpm = '0;
    logic        m_blz = 1'b0;
    logic [12:0] exp_vec;
    logic [12:0] obs;

    assign obs = {bus.seg, bus.dp, bus.an, bus.frame_done};

    // Expected {seg, dp, an, frame_done} after an edge taken at elapsed cycle t.
    function automatic logic [12:0] model_out(int t, logic [15:0] v, logic [3:0] dpm,
                                              logic blz);
        int         cnt;
        int         idx;
        logic [15:0] upper;
        logic       blank;
        logic       fd;
        logic [3:0] an_e;
        cnt   = t % D;
        idx   = (t / D) % N;
        upper = v >> (4 * idx);
        blank = (idx > 0) && blz && (upper == 16'h0);
        fd    = (cnt == D - 1) && (idx == N - 1);
        if (cnt == 0 || blank) return {7'b1111111, 1'b1, 4'b1111, fd};
        an_e = ~(4'b0001 << idx);
        return {seg_tab[upper[3:0]], ~dpm[idx], an_e, fd};
    endfunction

    // Advance one clock, updating the model at the edge; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            exp_vec = IDLE_VEC;
            m_t     = 0;
            m_val   = '0;
            m_dpm   = '0;
            m_blz   = 1'b0;
        end else begin
            exp_vec = model_out(m_t, m_val, m_dpm, m_blz);
            m_t++;
            if (bus.load) begin
                m_val = bus.value;
                m_dpm = bus.dp_mask;
                m_blz = bus.blank_lz;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.load = 1'b1;
        bus.value = 16'hFFFF;
        bus.dp_mask = 4'hF;
        bus.blank_lz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs !== IDLE_VEC) begin
                n_errors++;
                $display("FAIL reset cyc=%0d got=%b want=%b", k, obs, IDLE_VEC);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_scan();
        int fd_count = 0;
        reset_n = 1'b1;
        bus.value = 16'h12AF;
        bus.dp_mask = 4'b0000;
        bus.blank_lz = 1'b0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        n_checks++;
        if (obs !== exp_vec) begin
            n_errors++;
            $display("FAIL scan_first got=%b want=%b", obs, exp_vec);
        end
        for (int k = 0; k < 32; k++) begin
            tick();
            if (bus.frame_done === 1'b1) fd_count++;
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL scan t=%0d got=%b want=%b", m_t, obs, exp_vec);
            end
            if (k == 0) begin
                n_checks++;
                if (obs[12:1] !== {7'b0111000, 1'b1, 4'b1110}) begin
                    n_errors++;
                    $display("FAIL scan_digit0_F got=%b want=%b", obs[12:1],
                             {7'b0111000, 1'b1, 4'b1110});
                end
            end
        end
        n_checks++;
        if (fd_count != 2) begin
            n_errors++;
            $display("FAIL frame_done_count got=%0d want=2", fd_count);
        end
    endtask

    task automatic test_blank();
        bus.value = 16'h0005;
        bus.blank_lz = 1'b1;
        bus.dp_mask = 4'b0000;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL blank5 t=%0d got=%b want=%b", m_t, obs, exp_vec);
            end
            if (bus.an !== 4'b1111) begin
                n_checks++;
                if (bus.an !== 4'b1110 || bus.seg !== 7'b0100100) begin
                    n_errors++;
                    $display("FAIL blank5_lit an=%b seg=%b want an=1110 seg=0100100",
                             bus.an, bus.seg);
                end
            end
        end
        bus.value = 16'h0000;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL blank0 t=%0d got=%b want=%b", m_t, obs, exp_vec);
            end
            if (k > 0 && bus.an !== 4'b1111) begin
                n_checks++;
                if (bus.an !== 4'b1110 || bus.seg !== 7'b0000001) begin
                    n_errors++;
                    $display("FAIL blank0_lit an=%b seg=%b want an=1110 seg=0000001",
                             bus.an, bus.seg);
                end
            end
        end
    endtask

    task automatic test_dp();
        bus.value = 16'h0000;
        bus.blank_lz = 1'b0;
        bus.dp_mask = 4'b0100;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL dp t=%0d got=%b want=%b", m_t, obs, exp_vec);
            end
            if (k > 0) begin
                n_checks++;
                if (bus.dp !== (bus.an != 4'b1011)) begin
                    n_errors++;
                    $display("FAIL dp_slot an=%b dp=%b want dp=%b", bus.an, bus.dp,
                             (bus.an != 4'b1011));
                end
            end
        end
    endtask

    task automatic test_midslot_load();
        bus.value = 16'h0030;
        bus.blank_lz = 1'b0;
        bus.dp_mask = 4'b0000;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < 40 && (m_t % 16) != 6; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL mid_seek t=%0d got=%b want=%b", m_t, obs, exp_vec);
            end
        end
        n_checks++;
        if (obs !== {7'b0000110, 1'b1, 4'b1101, 1'b0}) begin
            n_errors++;
            $display("FAIL mid_before got=%b want=%b", obs, {7'b0000110, 1'b1, 4'b1101, 1'b0});
        end
        bus.value = 16'h0070;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        n_checks++;
        if (obs !== {7'b0000110, 1'b1, 4'b1101, 1'b0}) begin
            n_errors++;
            $display("FAIL mid_load_edge got=%b want=%b", obs, {7'b0000110, 1'b1, 4'b1101, 1'b0});
        end
        tick();
        n_checks++;
        if (obs !== {7'b0001111, 1'b1, 4'b1101, 1'b0}) begin
            n_errors++;
            $display("FAIL mid_after got=%b want=%b", obs, {7'b0001111, 1'b1, 4'b1101, 1'b0});
        end
    endtask

    task automatic test_wrap_load();
        bus.value = 16'h0030;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < 40 && (m_t % 16) != 3; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL wrap_seek t=%0d got=%b want=%b", m_t, obs, exp_vec);
            end
        end
        bus.value = 16'h0080;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        n_checks++;
        if (obs !== {7'b0000001, 1'b1, 4'b1110, 1'b0}) begin
            n_errors++;
            $display("FAIL wrap_edge got=%b want=%b", obs, {7'b0000001, 1'b1, 4'b1110, 1'b0});
        end
        tick();
        n_checks++;
        if (obs !== IDLE_VEC) begin
            n_errors++;
            $display("FAIL wrap_dead got=%b want=%b", obs, IDLE_VEC);
        end
        tick();
        n_checks++;
        if (obs !== {7'b0000000, 1'b1, 4'b1101, 1'b0}) begin
            n_errors++;
            $display("FAIL wrap_new got=%b want=%b", obs, {7'b0000000, 1'b1, 4'b1101, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 40 && (m_t % 16) != 10; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL rmid_seek t=%0d got=%b want=%b", m_t, obs, exp_vec);
            end
        end
        reset_n = 1'b0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        reset_n = 1'b1;
        n_checks++;
        if (obs !== IDLE_VEC) begin
            n_errors++;
            $display("FAIL rmid_reset got=%b want=%b", obs, IDLE_VEC);
        end
        tick();
        n_checks++;
        if (obs !== IDLE_VEC) begin
            n_errors++;
            $display("FAIL rmid_dead got=%b want=%b", obs, IDLE_VEC);
        end
        tick();
        n_checks++;
        if (obs !== {7'b0000001, 1'b1, 4'b1110, 1'b0}) begin
            n_errors++;
            $display("FAIL rmid_digit0 got=%b want=%b", obs, {7'b0000001, 1'b1, 4'b1110, 1'b0});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.load     = ($urandom_range(0, 2) == 0);
            bus.value    = 16'($urandom);
            if ($urandom_range(0, 1) == 0) bus.value = bus.value & 16'h00FF;
            bus.dp_mask  = 4'($urandom);
            bus.blank_lz = 1'($urandom);
            reset_n      = ($urandom_range(0, 39) != 0);
            tick();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL random k=%0d got=%b want=%b", k, obs, exp_vec);
            end
        end
        reset_n = 1'b1;
        bus.load = 1'b0;
    endtask

    initial begin
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.dp_mask  = '0;
        bus.blank_lz = 1'b0;
        exp_vec      = IDLE_VEC;
        test_reset();
        test_scan();
        test_blank();
        test_dp();
        test_midslot_load();
        test_wrap_load();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
